// File: rtl/apb_ucpd_pkg.sv
// Shared widths and helpers for the UCPD tick generator.
// Counter widths derive from these localparams; the prescaler spans 2^0 .. 2^(2^PSC_W-1).
package apb_ucpd_pkg;

  localparam int PSC_W     = 3;
  localparam int HDIV_W    = 6;
  localparam int TW_W      = 5;
  localparam int IFG_W     = 5;
  localparam int PSC_CNT_W = (1 << PSC_W) - 1;

  // Terminal count of the prescaler for a given exponent: 2^psc - 1.
  function automatic logic [PSC_CNT_W-1:0] psc_terminal(input logic [PSC_W-1:0] psc);
    logic [PSC_CNT_W:0] one_ext;
    one_ext = (PSC_CNT_W + 1)'(1);
    return PSC_CNT_W'((one_ext << psc) - one_ext);
  endfunction

endpackage

// File: rtl/apb_ucpd_tick_div.sv
// Enable-driven modulo-(div+1) counter with sync clear and sync load.
// Priority is clear, then load, then increment; clear or load suppresses the tick.
module apb_ucpd_tick_div #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_term;

  assign at_term = (cnt_q == div_i);
  assign tick_o  = en_i & at_term & ~clr_i & ~load_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = at_term ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_ucpd_tick_gen.sv
// Single-clock UCPD timing: every derived clock is a one-cycle enable strobe in ic_clk.
// Strobes are registered, so each appears the cycle after its count condition holds.
module apb_ucpd_tick_gen
  import apb_ucpd_pkg::*;
(
  input  logic              ic_clk,
  input  logic              ic_rst_n,
  input  logic [PSC_W-1:0]  psc_usbpdclk,
  input  logic [HDIV_W-1:0] hbitclkdiv,
  input  logic [TW_W-1:0]   transwin,
  input  logic [IFG_W-1:0]  ifrgap,
  input  logic              transmit_en,
  input  logic              bmc_en,
  input  logic              wait_en,
  input  logic              tx_eop_cmplt,
  input  logic              tx_sop_rst_cmplt,
  input  logic              rx_resync,
  output logic              ucpd_tick,
  output logic              tx_hbit_tick,
  output logic              tx_bit_tick,
  output logic              rx_hbit_tick,
  output logic              bypass_prescaler,
  output logic              transwin_en,
  output logic              ifrgap_en
);

  localparam int TWC_W = TW_W + 1;

  logic [PSC_W-1:0]     psc_sh_q;
  logic [HDIV_W-1:0]    hdiv_sh_q;
  logic                 ten_q;
  logic [PSC_CNT_W-1:0] psc_cnt_q, psc_cnt_d;
  logic                 bit_phase_q, bit_phase_d;
  logic [TWC_W-1:0]     tw_cnt_q, tw_cnt_d;
  logic [IFG_W-1:0]     ifg_cnt_q, ifg_cnt_d;

  logic ucpd_q, tx_hbit_q, tx_bit_q, rx_hbit_q, transwin_q, ifrgap_q;

  logic tx_rise, tx_edge, bypass, psc_wrap;
  logic ucpd_hit, tx_hit, rx_hit, tx_bit_hit;
  logic tw_run, tw_match, tw_hit;
  logic ifg_clr, ifg_run, ifg_match, ifg_hit;

  assign tx_rise  = transmit_en & ~ten_q;
  assign tx_edge  = transmit_en ^ ten_q;
  assign bypass   = (psc_sh_q == '0);
  assign psc_wrap = (psc_cnt_q == psc_terminal(psc_sh_q));

  // A TX restart discards a pending prescaler wrap so the first half-bit is full length.
  assign ucpd_hit = bypass | (psc_wrap & ~tx_rise);

  always_comb begin
    psc_cnt_d = psc_cnt_q + PSC_CNT_W'(1);
    if (tx_rise || psc_wrap) begin
      psc_cnt_d = '0;
    end
  end

  apb_ucpd_tick_div #(.W(HDIV_W)) u_tx_div (
    .clk_i      (ic_clk),
    .rst_ni     (ic_rst_n),
    .en_i       (ucpd_hit),
    .clr_i      (tx_rise),
    .load_i     (1'b0),
    .load_val_i ('0),
    .div_i      (hdiv_sh_q),
    .tick_o     (tx_hit)
  );

  // RX resync centres the next tick in the middle of a half-bit.
  apb_ucpd_tick_div #(.W(HDIV_W)) u_rx_div (
    .clk_i      (ic_clk),
    .rst_ni     (ic_rst_n),
    .en_i       (ucpd_hit),
    .clr_i      (1'b0),
    .load_i     (rx_resync),
    .load_val_i (hdiv_sh_q >> 1),
    .div_i      (hdiv_sh_q),
    .tick_o     (rx_hit)
  );

  assign tx_bit_hit = tx_hit & bit_phase_q;

  always_comb begin
    bit_phase_d = bit_phase_q;
    if (tx_rise) begin
      bit_phase_d = 1'b0;
    end else if (tx_hit) begin
      bit_phase_d = ~bit_phase_q;
    end
  end

  assign tw_run   = tx_hit & ~bmc_en & ~wait_en;
  assign tw_match = (tw_cnt_q == {1'b0, transwin});
  assign tw_hit   = tw_run & tw_match & ~tx_edge;

  always_comb begin
    tw_cnt_d = tw_cnt_q;
    if (tx_edge) begin
      tw_cnt_d = '0;
    end else if (tw_run) begin
      tw_cnt_d = tw_match ? '0 : tw_cnt_q + TWC_W'(1);
    end
  end

  assign ifg_clr   = tx_eop_cmplt | tx_sop_rst_cmplt;
  assign ifg_run   = wait_en & ucpd_hit;
  assign ifg_match = (ifg_cnt_q == ifrgap);
  assign ifg_hit   = ifg_run & ifg_match & ~ifg_clr;

  always_comb begin
    ifg_cnt_d = ifg_cnt_q;
    if (ifg_clr) begin
      ifg_cnt_d = '0;
    end else if (ifg_run) begin
      ifg_cnt_d = ifg_match ? '0 : ifg_cnt_q + IFG_W'(1);
    end
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      psc_sh_q    <= '0;
      hdiv_sh_q   <= '0;
      ten_q       <= 1'b0;
      psc_cnt_q   <= '0;
      bit_phase_q <= 1'b0;
      tw_cnt_q    <= '0;
      ifg_cnt_q   <= '0;
      ucpd_q      <= 1'b0;
      tx_hbit_q   <= 1'b0;
      tx_bit_q    <= 1'b0;
      rx_hbit_q   <= 1'b0;
      transwin_q  <= 1'b0;
      ifrgap_q    <= 1'b0;
    end else begin
      // Divider configuration is frozen for the whole of a transmission.
      if (!transmit_en) begin
        psc_sh_q  <= psc_usbpdclk;
        hdiv_sh_q <= hbitclkdiv;
      end
      ten_q       <= transmit_en;
      psc_cnt_q   <= psc_cnt_d;
      bit_phase_q <= bit_phase_d;
      tw_cnt_q    <= tw_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      ucpd_q      <= ucpd_hit;
      tx_hbit_q   <= tx_hit;
      tx_bit_q    <= tx_bit_hit;
      rx_hbit_q   <= rx_hit;
      transwin_q  <= tw_hit;
      ifrgap_q    <= ifg_hit;
    end
  end

  assign ucpd_tick        = ucpd_q;
  assign tx_hbit_tick     = tx_hbit_q;
  assign tx_bit_tick      = tx_bit_q;
  assign rx_hbit_tick     = rx_hbit_q;
  assign bypass_prescaler = bypass;
  assign transwin_en      = transwin_q;
  assign ifrgap_en        = ifrgap_q;

endmodule
